// File: rtl/traffic_light_control_pkg.sv
// Shared types and constants for the two-road traffic light controller:
// phase encoding, lamp patterns and default phase durations.
package traffic_pkg;

    typedef enum logic [2:0] {
        MG,
        MY,
        CG,
        CY,
        FLASH
    } state_t;

    localparam int unsigned CNT_W = 5;
    localparam int unsigned LED_W = 6;

    // Lamp order is {mR,mY,mG,cR,cY,cG}
    localparam logic [LED_W-1:0] LED_MG       = 6'b001_100;
    localparam logic [LED_W-1:0] LED_MY       = 6'b010_100;
    localparam logic [LED_W-1:0] LED_CG       = 6'b100_001;
    localparam logic [LED_W-1:0] LED_CY       = 6'b100_010;
    localparam logic [LED_W-1:0] LED_FLASH_ON = 6'b010_010;
    localparam logic [LED_W-1:0] LED_DARK     = 6'b000_000;

    localparam int unsigned TICK_DIV_DEF = 1;
    localparam int unsigned T_MG_DEF     = 25;
    localparam int unsigned T_MG_PK_DEF  = 30;
    localparam int unsigned T_CG_DEF     = 15;
    localparam int unsigned T_CG_PK_DEF  = 20;
    localparam int unsigned T_Y_DEF      = 3;
    localparam int unsigned T_PED_DEF    = 5;

    function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [LED_W-1:0] led_of(input state_t s, input logic f);
        logic [LED_W-1:0] led;
        case (s)
            MG:      led = LED_MG;
            MY:      led = LED_MY;
            CG:      led = LED_CG;
            CY:      led = LED_CY;
            FLASH:   led = f ? LED_FLASH_ON : LED_DARK;
            default: led = LED_MG;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/traffic_light_control_if.sv
// Sensor/request inputs and lamp/display outputs of the controller.
// The slave side is the controller; the master side is its environment.
interface traffic_light_control_if;
    logic       Cm;
    logic       Cc;
    logic       PQm;
    logic       PQc;
    logic       peak;
    logic       online;
    logic [4:0] countdown_time;
    logic [5:0] led_light;

    modport master (
        output Cm, Cc, PQm, PQc, peak, online,
        input  countdown_time, led_light
    );

    modport slave (
        input  Cm, Cc, PQm, PQc, peak, online,
        output countdown_time, led_light
    );
endinterface

// File: rtl/traffic_light_control_tick_gen.sv
// Countdown tick divider: tick is high for one clock every TICK_DIV clocks
// (always high when TICK_DIV is 1). clr restarts the division period.
module tick_gen #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic set,
    input  logic clr,
    output logic tick
);
    localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge set) begin
        if (!set) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_light_control.sv
// Two-road signal controller: MG -> MY -> CG -> CY phase sequencer with
// per-phase countdown, pedestrian caps, cross-road early release and flash override.
module traffic_light_control
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int unsigned T_MG     = T_MG_DEF,
    parameter int unsigned T_MG_PK  = T_MG_PK_DEF,
    parameter int unsigned T_CG     = T_CG_DEF,
    parameter int unsigned T_CG_PK  = T_CG_PK_DEF,
    parameter int unsigned T_Y      = T_Y_DEF,
    parameter int unsigned T_PED    = T_PED_DEF
) (
    input  logic                   clk,
    input  logic                   set,
    input  logic                   rst,
    traffic_light_control_if.slave bus
);
    localparam logic [CNT_W-1:0] MG_N  = CNT_W'(T_MG);
    localparam logic [CNT_W-1:0] MG_PK = CNT_W'(T_MG_PK);
    localparam logic [CNT_W-1:0] CG_N  = CNT_W'(T_CG);
    localparam logic [CNT_W-1:0] CG_PK = CNT_W'(T_CG_PK);
    localparam logic [CNT_W-1:0] Y_LEN = CNT_W'(T_Y);
    localparam logic [CNT_W-1:0] P_CAP = CNT_W'(T_PED);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   count, count_nx;
    logic               ped_m, ped_m_nx;
    logic               ped_c, ped_c_nx;
    logic               flash_f, flash_f_nx;
    logic [LED_W-1:0]   led, led_nx;
    logic [CNT_W-1:0]   dur_mg, dur_cg;
    logic               tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .set  (set),
        .clr  (rst),
        .tick (tick)
    );

    // Durations are sampled at the moment a phase is loaded
    assign dur_mg = bus.peak ? MG_PK : MG_N;
    assign dur_cg = bus.peak ? CG_PK : CG_N;

    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        count_nx   = count;
        ped_m_nx   = ped_m | bus.PQm;
        ped_c_nx   = ped_c | bus.PQc;
        flash_f_nx = flash_f;

        if (bus.online) begin
            state_nx   = FLASH;
            count_nx   = '0;
            flash_f_nx = (state != FLASH) ? 1'b1 : (flash_f ^ tick);
        end else if (state == FLASH) begin
            state_nx = MG;
            count_nx = dur_mg;
        end else if (tick) begin
            if (count <= CNT_W'(1)) begin
                case (state)
                    MG: begin
                        if (bus.Cc || ped_c || ped_m) begin
                            state_nx = MY;
                            count_nx = Y_LEN;
                        end else begin
                            count_nx = dur_mg;
                        end
                    end
                    MY: begin
                        state_nx = CG;
                        count_nx = dur_cg;
                    end
                    CG: begin
                        state_nx = CY;
                        count_nx = Y_LEN;
                    end
                    default: begin
                        state_nx = MG;
                        count_nx = dur_mg;
                    end
                endcase
            end else begin
                count_nx = count - CNT_W'(1);
                if (state == MG && ped_m) begin
                    count_nx = min_cnt(count_nx, P_CAP);
                end
                // Cross green is released early when nobody is waiting on it
                if (state == CG) begin
                    if (ped_c) begin
                        count_nx = min_cnt(count_nx, P_CAP);
                    end else if (!bus.Cc && count > Y_LEN) begin
                        count_nx = Y_LEN;
                    end
                end
            end
        end

        if (state_nx == CG && state != CG) begin
            ped_m_nx = 1'b0;
        end
        if (state_nx == MG && state != MG) begin
            ped_c_nx = 1'b0;
        end

        led_nx = led_of(state_nx, flash_f_nx);
    end

    always_ff @(posedge clk or negedge set) begin
        if (!set) begin
            state   <= MG;
            count   <= MG_N;
            ped_m   <= 1'b0;
            ped_c   <= 1'b0;
            flash_f <= 1'b1;
            led     <= LED_MG;
        end else if (rst) begin
            state   <= MG;
            count   <= MG_N;
            ped_m   <= 1'b0;
            ped_c   <= 1'b0;
            flash_f <= 1'b1;
            led     <= LED_MG;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            ped_m   <= ped_m_nx;
            ped_c   <= ped_c_nx;
            flash_f <= flash_f_nx;
            led     <= led_nx;
        end
    end

    assign bus.countdown_time = count;
    assign bus.led_light      = led;

endmodule

// File: tb/tb_traffic_light_control.sv
// Directed bench for traffic_light_control: vector table for a pedestrian-capped
// cross green, plus sequences for normal/peak cycling, early release, flash and resets.
module tb_traffic_light_control;

    localparam logic [5:0] L_MG  = 6'b001_100;
    localparam logic [5:0] L_MY  = 6'b010_100;
    localparam logic [5:0] L_CG  = 6'b100_001;
    localparam logic [5:0] L_CY  = 6'b100_010;
    localparam logic [5:0] L_FON = 6'b010_010;
    localparam logic [5:0] L_OFF = 6'b000_000;

    typedef struct {
        logic       cm;
        logic       cc;
        logic       pqm;
        logic       pqc;
        logic       peak;
        logic       online;
        logic [4:0] exp_cnt;
        logic [5:0] exp_led;
    } vec_t;

    logic clk = 1'b0;
    logic set;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[13];

    traffic_light_control_if bus();

    traffic_light_control dut (
        .clk (clk),
        .set (set),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [4:0] cnt, input logic [5:0] led);
        check({name, "_cnt"}, 32'(bus.countdown_time), 32'(cnt));
        check({name, "_led"}, 32'(bus.led_light), 32'(led));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cm, input logic cc, input logic pqm, input logic pqc,
                         input logic peak, input logic online);
        bus.Cm     = cm;
        bus.Cc     = cc;
        bus.PQm    = pqm;
        bus.PQc    = pqc;
        bus.peak   = peak;
        bus.online = online;
    endtask

    // Checks a phase from its first cycle to its last, ending on the next phase's first cycle
    task automatic expect_phase(input string name, input int len, input logic [5:0] led);
        for (int i = len; i >= 1; i--) begin
            check_out($sformatf("%s_%0d", name, i), 5'(i), led);
            step();
        end
    endtask

    initial begin
        //          cm    cc    pqm   pqc   peak  onl   cnt     led
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd14, L_CG};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd13, L_CG};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, L_CG};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd11, L_CG};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5,  L_CG};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4,  L_CG};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  L_CG};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  L_CG};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1,  L_CG};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  L_CY};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  L_CY};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1,  L_CY};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd25, L_MG};

        // Reset state, then an idle main green that counts down and reloads
        set = 1'b0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_out("reset", 5'd25, L_MG);
        set = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            check_out($sformatf("idle_mg_%0d", 25 - k), 5'(25 - k), L_MG);
        end
        step();
        check_out("idle_reload", 5'd25, L_MG);

        // Peak timing picked up at the MG reload, then a full peak cycle
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_phase("mg_pre_peak", 25, L_MG);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_phase("mg_peak", 30, L_MG);
        expect_phase("my_peak", 3, L_MY);
        expect_phase("cg_peak", 20, L_CG);
        expect_phase("cy_peak", 3, L_CY);
        check_out("mg_peak_again", 5'd30, L_MG);

        // Main-road pedestrian request with no vehicles anywhere
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step();
        check_out("mg_pre_ped", 5'd20, L_MG);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_out("mg_ped_latch", 5'd19, L_MG);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_phase("mg_ped_cap", 5, L_MG);
        expect_phase("my_ped", 3, L_MY);
        check_out("cg_entry", 5'd15, L_CG);
        step();
        expect_phase("cg_release", 3, L_CG);
        expect_phase("cy_ped", 3, L_CY);
        expect_phase("mg_pedm_cleared", 25, L_MG);
        check_out("mg_reload_noped", 5'd25, L_MG);

        // Cross-road demand, then the vector table: cross pedestrian cap in CG
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_phase("mg_cc", 25, L_MG);
        expect_phase("my_cc", 3, L_MY);
        check_out("cg_cc_entry", 5'd15, L_CG);
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].cm, vecs[i].cc, vecs[i].pqm, vecs[i].pqc, vecs[i].peak, vecs[i].online);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_led);
        end

        // Flash override entered mid cross green
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_phase("mg_e", 25, L_MG);
        expect_phase("my_e", 3, L_MY);
        check_out("cg_e", 5'd15, L_CG);
        step();
        step();
        check_out("cg_e13", 5'd13, L_CG);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_out("flash_on", 5'd0, L_FON);
        step();
        check_out("flash_off", 5'd0, L_OFF);
        step();
        check_out("flash_on2", 5'd0, L_FON);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_out("flash_exit", 5'd25, L_MG);

        // Synchronous restart mid CY, then asynchronous reset mid MY
        expect_phase("mg_f", 25, L_MG);
        expect_phase("my_f", 3, L_MY);
        expect_phase("cg_f", 15, L_CG);
        check_out("cy_f", 5'd3, L_CY);
        step();
        check_out("cy_f2", 5'd2, L_CY);
        rst = 1'b1;
        step();
        check_out("rst_sync", 5'd25, L_MG);
        rst = 1'b0;
        step();
        expect_phase("mg_g", 24, L_MG);
        check_out("my_g", 5'd3, L_MY);
        step();
        check_out("my_g2", 5'd2, L_MY);
        set = 1'b0;
        #1;
        check_out("set_async", 5'd25, L_MG);
        step();
        check_out("set_held", 5'd25, L_MG);
        set = 1'b1;
        step();
        check_out("set_release", 5'd24, L_MG);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
